regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port general-purpose register file for the CPU datapath, successor to the single-write, two-read register file. Adds configurable width, depth and read-port count, a second write port for the multi-cycle unit (load/divide writeback), optional write-to-read bypass, and a per-register busy scoreboard that the decode stage uses to stall on pending producers. It sits between decode (read and issue) and writeback (two writers).

## Interface
- DW, 32: data width in bits.
- AW, 5: address width; depth = 2^AW.
- NRD, 2: number of read ports.
- BYPASS, 1: 1 = same-cycle write data and busy clear are forwarded to read outputs; 0 = reads return stored state only.
- ZERO_R0, 1: 1 = register 0 is hard-wired to zero and never busy.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- wr0_en  in  1  write port 0 enable (main pipeline writeback).
- wr0_addr  in  AW  write port 0 address.
- wr0_data  in  DW  write port 0 data.
- wr1_en  in  1  write port 1 enable (multi-cycle unit writeback).
- wr1_addr  in  AW  write port 1 address.
- wr1_data  in  DW  write port 1 data.
- rd_addr  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  per-port flag: the addressed register has a pending producer.
- busy_set_en  in  1  mark a register busy (multi-cycle op issued).
- busy_set_addr  in  AW  register to mark busy.
- busy_cnt  out  AW+1  registered count of busy registers.

## Operation
- Storage: 2^AW x DW registers plus 2^AW busy bits.
- Writes: on the clock edge, if wrN_en is high, reg[wrN_addr] <= wrN_data. If both ports target the same address, port 1 wins.
- Register 0 with ZERO_R0=1: writes are ignored, reads return 0, busy_set is ignored, and rd_busy is 0.
- Busy bits:
  - busy_set_en sets busy[busy_set_addr].
  - Any enabled write to an address clears its busy bit.
  - Set and clear to the same address in the same cycle: set wins. The new producer supersedes the old one.
- busy_cnt equals the number of set busy bits and is updated on the same edge as the busy bits. It is never negative and saturates structurally at 2^AW.
- Reads, per port k:
  - With BYPASS=1: if wr1 targets rd_addr[k] (a valid target, i.e. not register 0 under ZERO_R0), return wr1_data. Otherwise, if wr0 targets it, return wr0_data. Otherwise return the stored value.
  - With BYPASS=0: always return the stored value.
- rd_busy[k]:
  - Equals busy[rd_addr[k]].
  - With BYPASS=1, it is forced to 0 when a write to that address occurs in the same cycle and there is no same-cycle busy_set to that address.
- While reset is high, rd_data and rd_busy read as 0, with no bypass.

## Timing
- Reset, applied asynchronously: all registers, busy bits and busy_cnt are 0. rd_data = 0, rd_busy = 0, busy_cnt = 0.
- Writes, busy set and busy clear take effect at the first rising edge after the inputs are sampled. Write-to-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- rd_data and rd_busy are purely combinational from rd_addr, the write ports and the stored state.
- busy_cnt is registered and reflects the busy bits one edge after the set/clear request.
- Reset asserted mid-operation: pending writes and busy_set in that cycle are discarded. The first post-reset edge behaves as a fresh start.

## Test plan
- Reset, then read all addresses on every port → rd_data = 0, rd_busy = 0, busy_cnt = 0.
- wr0 writes r5 = 0x12345678. Same cycle, read r5: BYPASS=1 → 0x12345678; BYPASS=0 → old value 0, then 0x12345678 the next cycle.
- wr0 writes r7 = 0xAAAA0000 and wr1 writes r7 = 0x5555FFFF in the same cycle → next cycle r7 = 0x5555FFFF. Same-cycle bypass read also = 0x5555FFFF.
- With ZERO_R0=1, write r0 = 0xFFFFFFFF and busy_set r0 → rd_data = 0, rd_busy = 0, busy_cnt unchanged.
- Scoreboard sequence:
  - busy_set r3, then r9 → busy_cnt 1, then 2.
  - wr1 writes r3 → rd_busy for r3 = 0 in the same cycle (BYPASS=1), busy_cnt = 1 next cycle.
  - busy_set r9 together with a wr0 write to r9 → r9 stays busy, busy_cnt stays 1.
- Populate r1 to r31 with nonzero values and three busy bits, then pulse reset mid-cycle asynchronously → all outputs are 0 immediately, and busy_cnt = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with dual writeback, optional bypass and busy scoreboard.
module regfile_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DW-1:0]     wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DW-1:0]     wr1_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              busy_set_en,
  input  logic [AW-1:0]     busy_set_addr,
  output logic [AW:0]       busy_cnt
);
  localparam int DEPTH = 2**AW;
  logic [DW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [AW:0] cnt_nxt;
  logic wr0_v, wr1_v, set_v;
  // register 0 under ZERO_R0 is never a valid target for writes or busy marking
  assign wr0_v = wr0_en && !(ZERO_R0 != 0 && wr0_addr == '0);
  assign wr1_v = wr1_en && !(ZERO_R0 != 0 && wr1_addr == '0);
  assign set_v = busy_set_en && !(ZERO_R0 != 0 && busy_set_addr == '0);
  always_comb begin
    busy_nxt = busy;
    if (wr0_v) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_v) busy_nxt[wr1_addr] = 1'b0;
    if (set_v) busy_nxt[busy_set_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr0_v) mem[wr0_addr] <= wr0_data;
      if (wr1_v) mem[wr1_addr] <= wr1_data;
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic h0, h1, hs;
    assign a = rd_addr[k*AW +: AW];
    assign h0 = (BYPASS != 0) && wr0_v && wr0_addr == a;
    assign h1 = (BYPASS != 0) && wr1_v && wr1_addr == a;
    assign hs = set_v && busy_set_addr == a;
    assign rd_data[k*DW +: DW] = reset ? '0 : h1 ? wr1_data : h0 ? wr0_data : mem[a];
    assign rd_busy[k] = !reset && busy[a] && !((h0 || h1) && !hs);
  end
endmodule
